// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: operation
// encoding and default datapath width.
package logic_unit_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/logic_skid_buf.sv
// Two-entry valid/ready register stage (output register plus skid register)
// with a registered in_ready that is low exactly while the skid entry is full.
module logic_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_n;
  logic [W-1:0] out_data_q,  out_data_n;
  logic         skid_valid_q, skid_valid_n;
  logic [W-1:0] skid_data_q,  skid_data_n;
  logic         in_ready_q,   in_ready_n;
  logic         accept, consume;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  // in_ready_q mirrors !skid_valid_q, so accept and a skid refill never coincide.
  always_comb begin
    out_valid_n  = out_valid_q;
    out_data_n   = out_data_q;
    skid_valid_n = skid_valid_q;
    skid_data_n  = skid_data_q;
    if (consume && skid_valid_q) begin
      out_data_n   = skid_data_q;
      skid_valid_n = 1'b0;
    end else if (consume || !out_valid_q) begin
      out_valid_n = accept;
      if (accept) begin
        out_data_n = in_data;
      end
    end else if (accept) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end
    in_ready_n = ~skid_valid_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_n;
      out_data_q   <= out_data_n;
      skid_valid_q <= skid_valid_n;
      skid_data_q  <= skid_data_n;
      in_ready_q   <= in_ready_n;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: combinational op decode feeding a two-entry
// skid buffer. Define LOGIC_PARITY_EN to add a registered even-parity output.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y
`ifdef LOGIC_PARITY_EN
  ,
  output logic             out_par
`endif
);

`ifdef LOGIC_PARITY_EN
  localparam int unsigned PW = WIDTH + 1;
`else
  localparam int unsigned PW = WIDTH;
`endif

  op_e             op;
  logic [WIDTH-1:0] y;
  logic [PW-1:0]    in_pl;
  logic [PW-1:0]    out_pl;

  assign op = op_e'(in_op);

  always_comb begin
    y = '0;
    case (op)
      OP_NOT:  y = ~in_a;
      OP_AND:  y = in_a & in_b;
      OP_OR:   y = in_a | in_b;
      OP_XOR:  y = in_a ^ in_b;
      OP_NAND: y = ~(in_a & in_b);
      OP_NOR:  y = ~(in_a | in_b);
      OP_XNOR: y = ~(in_a ^ in_b);
      OP_PASS: y = in_a;
      default: y = '0;
    endcase
  end

`ifdef LOGIC_PARITY_EN
  // Parity travels with the result so it stays aligned through the skid entry.
  assign in_pl   = {^y, y};
  assign out_par = out_pl[WIDTH];
`else
  assign in_pl = y;
`endif
  assign out_y = out_pl[WIDTH-1:0];

  logic_skid_buf #(
    .W (PW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=8): directed sweeps plus
// randomized traffic with random back-pressure against a truth-table model.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
`ifdef LOGIC_PARITY_EN
  logic       out_par;
`endif

  logic_unit_pipe #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
`ifdef LOGIC_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-bit truth table indexed by {a,b}
  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [3:0] tt;
    logic [7:0] r;
    case (op)
      3'd0: tt = 4'b0011;
      3'd1: tt = 4'b1000;
      3'd2: tt = 4'b1110;
      3'd3: tt = 4'b0110;
      3'd4: tt = 4'b0111;
      3'd5: tt = 4'b0001;
      3'd6: tt = 4'b1001;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  // Monitor: a transfer seen at a falling edge completes at the next rising edge.
  exp_t       mon_e;
  bit         held = 0;
  logic [7:0] held_y;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0h want none", out_y);
        end else begin
          mon_e = sbq.pop_front();
          check("out_y", {56'b0, out_y}, {56'b0, mon_e.y});
`ifdef LOGIC_PARITY_EN
          check("out_par", {63'b0, out_par}, {63'b0, ^mon_e.y});
`endif
          if (mon_e.lat) check("latency", 64'(cyc + 1 - mon_e.acc), 64'd1);
        end
      end
      if (out_valid && !out_ready) begin
        if (held) check("hold_stable", {56'b0, out_y}, {56'b0, held_y});
        held   = 1;
        held_y = out_y;
      end else begin
        held = 0;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input bit lat, input bit keep);
    exp_t e;
    bit   done;
    done     = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        if (keep) begin
          e.y = exp; e.acc = cyc + 1; e.lat = lat;
          sbq.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  logic [7:0] sweep_exp [8] = '{8'h5A, 8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA5};

  initial begin
    exp_t e;
    bit   acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_y", {56'b0, out_y}, 64'd0);
`ifdef LOGIC_PARITY_EN
    check("rst_out_par", {63'b0, out_par}, 64'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_first_edge", {63'b0, in_ready}, 64'd1);
    check("out_valid_idle", {63'b0, out_valid}, 64'd0);

    // Op sweep with a free-running sink
    out_ready = 1'b1;
    for (int op = 0; op < 8; op++) send(3'(op), 8'hA5, 8'h0F, sweep_exp[op], 1, 1);
    drain();

    // Back-pressure: two fill output+skid, third waits
    out_ready = 1'b0;
    send(3'd3, 8'hFF, 8'h01, 8'hFE, 0, 1);
    send(3'd3, 8'h00, 8'h00, 8'h00, 0, 1);
    check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
    check("bp_out_valid", {63'b0, out_valid}, 64'd1);
    check("bp_out_y", {56'b0, out_y}, 64'hFE);
    in_valid = 1'b1; in_op = 3'd1; in_a = 8'hF0; in_b = 8'h3C;
    repeat (2) @(posedge clk);
    #1;
    check("bp_still_blocked", {63'b0, in_ready}, 64'd0);
    check("bp_out_y_held", {56'b0, out_y}, 64'hFE);
    out_ready = 1'b1;
    send(3'd1, 8'hF0, 8'h3C, 8'h30, 0, 1);
    drain();

    // Simultaneous accept and consume with empty skid
    send(3'd7, 8'h11, 8'h00, 8'h11, 1, 1);
    send(3'd0, 8'h00, 8'h00, 8'hFF, 1, 1);
    check("simul_out_valid", {63'b0, out_valid}, 64'd1);
    check("simul_out_y", {56'b0, out_y}, 64'hFF);
    drain();

`ifdef LOGIC_PARITY_EN
    send(3'd7, 8'h07, 8'h00, 8'h07, 0, 1);
    check("par_07", {63'b0, out_par}, 64'd1);
    send(3'd7, 8'h03, 8'h00, 8'h03, 0, 1);
    check("par_03", {63'b0, out_par}, 64'd0);
    drain();
`endif

    // Reset while both entries are full; results must vanish
    out_ready = 1'b0;
    send(3'd3, 8'h12, 8'h34, 8'h00, 0, 0);
    send(3'd2, 8'h56, 8'h78, 8'h00, 0, 0);
    check("stall_full", {63'b0, in_ready}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'b0, in_ready}, 64'd0);
    check("midrst_out_y", {56'b0, out_y}, 64'd0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready_first_edge", {63'b0, in_ready}, 64'd1);
    check("midrst_no_stale", {63'b0, out_valid}, 64'd0);
    repeat (5) @(posedge clk);
    #1;

    // Random traffic and back-pressure
    for (int c = 0; c < 600; c++) begin
      if (c >= 400 && !in_valid) break;
      out_ready = (c >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!in_valid && c < 400 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_op    = 3'($urandom);
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin
        e.y = model(in_op, in_a, in_b); e.acc = cyc + 1; e.lat = 0;
        sbq.push_back(e);
      end
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
